antirrebote: RTL and testbench
==============================

ANTIRREBOTE -- requirements
Module: antirrebote

Interface
REQ-001 The block SHALL have parameter CNT_MAX, default 4, meaning the number of consecutive clock edges an input must differ from its debounced level before that level changes; legal range 2..255.
REQ-002 The block SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port q_i  input  4  already-synchronized channel levels, driven by the upstream sincronizador Q output; no further synchronization is performed here.
REQ-005 The block SHALL have port db_o  output  4  debounced level per channel, registered.
REQ-006 The block SHALL have port rise_o  output  4  one-cycle pulse per channel when db_o goes 0->1, registered.
REQ-007 The block SHALL have port fall_o  output  4  one-cycle pulse per channel when db_o goes 1->0, registered; content depends on REQ-021.

Function
REQ-008 Each of the 4 channels SHALL be an independent FSM with states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO and a private counter of width $clog2(CNT_MAX).
REQ-009 In STABLE_LO: q_i=0 -> stay, cnt=0; q_i=1 -> WAIT_HI, cnt=1.
REQ-010 In WAIT_HI: q_i=0 -> STABLE_LO, cnt=0, no pulse; q_i=1 and cnt<CNT_MAX-1 -> stay, cnt+1; q_i=1 and cnt==CNT_MAX-1 -> STABLE_HI, cnt=0, db_o=1, rise_o=1 for exactly that cycle.
REQ-011 STABLE_HI/WAIT_LO SHALL mirror REQ-009/010 with q_i inverted, db_o=0 and fall_o pulse on commit.
REQ-012 Latency: db_o SHALL change on the CNT_MAX-th consecutive rising edge at which q_i differs from db_o, and the edge pulse SHALL assert on the same edge as the db_o change.
REQ-013 Any single-cycle return of q_i to the db_o value during WAIT SHALL abort the transition and restart the count from zero; glitches shorter than CNT_MAX cycles SHALL never reach db_o.
REQ-014 rise_o and fall_o SHALL be 0 in every cycle without a commit; a channel SHALL never assert rise_o and fall_o together.
REQ-015 Channels SHALL not interact; simultaneous commits on several channels SHALL produce simultaneous pulses.
REQ-016 The counter SHALL never exceed CNT_MAX-1 and SHALL never wrap.

Reset
REQ-017 While rst=1, every channel SHALL be in STABLE_LO with cnt=0 and db_o=0, rise_o=0, fall_o=0, regardless of clk.
REQ-018 Reset asserted mid-WAIT SHALL discard the pending count with no pulse; after release, the first edge SHALL be evaluated per REQ-009.
REQ-019 A channel whose q_i=1 at reset release SHALL reach db_o=1 with a rise_o pulse after CNT_MAX edges.

Configuration
REQ-020 Macro ANTIRREBOTE_FALL_EDGE_EN SHALL control falling-edge pulse generation.
REQ-021 Macro defined: fall_o per REQ-011; macro undefined: fall_o SHALL be tied to 4'b0000, with the port still present and db_o/rise_o unchanged.

Structure
REQ-022 Package antirrebote_pkg SHALL hold the state enum (STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO) and the channel-count constant N_CH=4.
REQ-023 One sub-module antirrebote_canal SHALL implement one channel (FSM, counter, db/rise/fall registers); antirrebote SHALL instantiate it N_CH times.

Verification
REQ-024 Reset: rst=1 with q_i=4'hF -> db_o=0, rise_o=0, fall_o=0 immediately and while held.
REQ-025 Clean step: CNT_MAX=4, q_i 0->4'b0001 held -> db_o[0]=1 on the 4th edge, rise_o=4'b0001 for exactly one cycle.
REQ-026 Glitch: q_i[1]=1 for 3 edges then 0 with CNT_MAX=4 -> db_o stays 0 and rise_o stays 0; q_i[1] then held 1 -> commit 4 edges later.
REQ-027 Release: from db_o=4'hF, q_i=4'h0 held -> db_o=0 after 4 edges; fall_o=4'hF for one cycle with the macro defined and 4'h0 without it.
REQ-028 Reset mid-wait: q_i[2]=1 for 2 edges, pulse rst, q_i[2] still 1 -> no pulse before reset; db_o[2]=1 4 edges after release.
REQ-029 Random: 10 random 4-bit q_i values each held 5 edges with CNT_MAX=4 -> db_o matches a reference model and never changes on a run shorter than 4.

Source files
------------

// File: rtl/antirrebote_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | antirrebote_pkg                                                      |
// | Shared channel count and per-channel debounce state encoding.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package antirrebote_pkg;

  localparam int N_CH = 4;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/antirrebote_canal.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | antirrebote_canal                                                    |
// | One debounce channel: FSM, run counter, level and edge registers.    |
// | ANTIRREBOTE_FALL_EDGE_EN enables the falling-edge pulse.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module antirrebote_canal
  import antirrebote_pkg::*;
#(
  parameter int CNT_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic q_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int c_cnt_w = $clog2(CNT_MAX);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CNT_MAX - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               r_db;
  logic               r_rise;
  logic               w_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The count restarts from zero on every abort and every commit, so it never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      STABLE_LO: begin
        if (q_i) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = c_cnt_one;
        end
      end
      WAIT_HI: begin
        if (!q_i) begin
          w_state_nxt = STABLE_LO;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = STABLE_HI;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      STABLE_HI: begin
        if (!q_i) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = c_cnt_one;
        end
      end
      WAIT_LO: begin
        if (q_i) begin
          w_state_nxt = STABLE_HI;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = STABLE_LO;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      default: w_state_nxt = STABLE_LO;
    endcase
  end

  // A commit is the only WAIT->STABLE move into the opposite level.
  assign w_rise = (r_state == WAIT_HI) && (w_state_nxt == STABLE_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db   <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_db   <= (w_state_nxt == STABLE_HI) || (w_state_nxt == WAIT_LO);
      r_rise <= w_rise;
    end
  end

  assign db_o   = r_db;
  assign rise_o = r_rise;

`ifdef ANTIRREBOTE_FALL_EDGE_EN
  logic r_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fall <= 1'b0;
    end else begin
      r_fall <= (r_state == WAIT_LO) && (w_state_nxt == STABLE_LO);
    end
  end

  assign fall_o = r_fall;
`else
  assign fall_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/antirrebote.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | antirrebote                                                          |
// | N_CH independent debounce channels with registered edge pulses.      |
// | ANTIRREBOTE_FALL_EDGE_EN enables fall_o; otherwise it reads zero.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module antirrebote
  import antirrebote_pkg::*;
#(
  parameter int CNT_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] q_i,
  output logic [N_CH-1:0] db_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o
);

  for (genvar g = 0; g < N_CH; g++) begin : g_canal
    antirrebote_canal #(
      .CNT_MAX (CNT_MAX)
    ) u_canal (
      .clk    (clk),
      .rst    (rst),
      .q_i    (q_i[g]),
      .db_o   (db_o[g]),
      .rise_o (rise_o[g]),
      .fall_o (fall_o[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_antirrebote.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_antirrebote                                                       |
// | Self-checking bench: directed scenarios plus random levels vs model. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_antirrebote;

  localparam int CNT_MAX = 4;
`ifdef ANTIRREBOTE_FALL_EDGE_EN
  localparam logic c_fall_en = 1'b1;
`else
  localparam logic c_fall_en = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] q;
  logic [3:0] db_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;

  int n_cmp;
  int n_err;

  // Reference: a level flips after CNT_MAX consecutive differing samples.
  logic [3:0] m_db;
  logic [3:0] m_rise;
  logic [3:0] m_fall;
  int         m_run [4];

  antirrebote #(
    .CNT_MAX (CNT_MAX)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .q_i    (q),
    .db_o   (db_o),
    .rise_o (rise_o),
    .fall_o (fall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_db   = 4'h0;
    m_rise = 4'h0;
    m_fall = 4'h0;
    for (int ch = 0; ch < 4; ch++) m_run[ch] = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_rise = 4'h0;
    m_fall = 4'h0;
    for (int ch = 0; ch < 4; ch++) begin
      if (q[ch] !== m_db[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == CNT_MAX) begin
          m_db[ch]   = q[ch];
          m_rise[ch] = q[ch];
          m_fall[ch] = ~q[ch] & c_fall_en;
          m_run[ch]  = 0;
        end
      end else begin
        m_run[ch] = 0;
      end
    end
  endtask

  task automatic do_reset(input logic [3:0] qv);
    q   = qv;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    q   = 4'hF;
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({db_o, rise_o, fall_o} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_immediate: got db=%h rise=%h fall=%h expected all 0", db_o, rise_o, fall_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({db_o, rise_o, fall_o} !== 12'h000) begin
        n_err++;
        $display("FAIL reset_held: got db=%h rise=%h fall=%h expected all 0", db_o, rise_o, fall_o);
      end
    end
    rst = 1'b0;
    model_clear();
    // q held high through release must commit after CNT_MAX edges.
    for (int e = 1; e <= CNT_MAX + 1; e++) begin
      tick();
      n_cmp++;
      if (db_o !== ((e >= CNT_MAX) ? 4'hF : 4'h0) || rise_o !== ((e == CNT_MAX) ? 4'hF : 4'h0)) begin
        n_err++;
        $display("FAIL reset_release e%0d: got db=%h rise=%h expected db=%h rise=%h", e, db_o, rise_o,
                 (e >= CNT_MAX) ? 4'hF : 4'h0, (e == CNT_MAX) ? 4'hF : 4'h0);
      end
    end
  endtask

  task automatic test_clean_step();
    do_reset(4'h0);
    tick();
    q = 4'b0001;
    for (int e = 1; e <= CNT_MAX + 2; e++) begin
      tick();
      n_cmp++;
      if (db_o !== ((e >= CNT_MAX) ? 4'h1 : 4'h0) || rise_o !== ((e == CNT_MAX) ? 4'h1 : 4'h0) || fall_o !== 4'h0) begin
        n_err++;
        $display("FAIL clean_step e%0d: got db=%h rise=%h fall=%h", e, db_o, rise_o, fall_o);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset(4'h0);
    q = 4'b0010;
    for (int e = 1; e <= CNT_MAX - 1; e++) begin
      tick();
      n_cmp++;
      if (db_o !== 4'h0 || rise_o !== 4'h0) begin
        n_err++;
        $display("FAIL glitch_hold e%0d: got db=%h rise=%h expected 0 0", e, db_o, rise_o);
      end
    end
    q = 4'b0000;
    tick();
    n_cmp++;
    if (db_o !== 4'h0 || rise_o !== 4'h0) begin
      n_err++;
      $display("FAIL glitch_abort: got db=%h rise=%h expected 0 0", db_o, rise_o);
    end
    q = 4'b0010;
    for (int e = 1; e <= CNT_MAX; e++) begin
      tick();
      n_cmp++;
      if (db_o !== ((e == CNT_MAX) ? 4'h2 : 4'h0) || rise_o !== ((e == CNT_MAX) ? 4'h2 : 4'h0)) begin
        n_err++;
        $display("FAIL glitch_recommit e%0d: got db=%h rise=%h", e, db_o, rise_o);
      end
    end
  endtask

  task automatic test_release();
    logic [3:0] exp_fall;
    exp_fall = c_fall_en ? 4'hF : 4'h0;
    do_reset(4'hF);
    for (int e = 1; e <= CNT_MAX; e++) tick();
    n_cmp++;
    if (db_o !== 4'hF) begin
      n_err++;
      $display("FAIL release_setup: got db=%h expected f", db_o);
    end
    q = 4'h0;
    for (int e = 1; e <= CNT_MAX + 1; e++) begin
      tick();
      n_cmp++;
      if (db_o !== ((e >= CNT_MAX) ? 4'h0 : 4'hF) || fall_o !== ((e == CNT_MAX) ? exp_fall : 4'h0) || rise_o !== 4'h0) begin
        n_err++;
        $display("FAIL release e%0d: got db=%h fall=%h rise=%h expected db=%h fall=%h", e, db_o, fall_o, rise_o,
                 (e >= CNT_MAX) ? 4'h0 : 4'hF, (e == CNT_MAX) ? exp_fall : 4'h0);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset(4'h0);
    q = 4'b0100;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({db_o, rise_o, fall_o} !== 12'h000) begin
      n_err++;
      $display("FAIL midwait_reset: got db=%h rise=%h fall=%h expected all 0", db_o, rise_o, fall_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    for (int e = 1; e <= CNT_MAX; e++) begin
      tick();
      n_cmp++;
      if (db_o !== ((e == CNT_MAX) ? 4'h4 : 4'h0) || rise_o !== ((e == CNT_MAX) ? 4'h4 : 4'h0)) begin
        n_err++;
        $display("FAIL midwait_release e%0d: got db=%h rise=%h", e, db_o, rise_o);
      end
    end
  endtask

  task automatic test_random();
    do_reset(4'h0);
    for (int v = 0; v < 10; v++) begin
      q = 4'($urandom_range(0, 15));
      for (int e = 0; e < 5; e++) begin
        tick();
        n_cmp++;
        if (db_o !== m_db || rise_o !== m_rise || fall_o !== m_fall) begin
          n_err++;
          $display("FAIL random v%0d e%0d q=%h: got db=%h rise=%h fall=%h expected db=%h rise=%h fall=%h",
                   v, e, q, db_o, rise_o, fall_o, m_db, m_rise, m_fall);
        end
        n_cmp++;
        if ((rise_o & fall_o) !== 4'h0) begin
          n_err++;
          $display("FAIL random_both_edges v%0d e%0d: got rise=%h fall=%h expected disjoint", v, e, rise_o, fall_o);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    q     = 4'h0;
    model_clear();
    test_reset();
    test_clean_step();
    test_glitch();
    test_release();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
